product_accumulator: RTL and testbench

//   Downstream consumer of the 32x32 Wallace multiplier's 64-bit product. Sums a

---
 rtl/product_accumulator_if.sv | 22 ++
 rtl/product_accumulator.sv | 50 +++++
 tb/tb_product_accumulator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product intake and result handshake bundle for the accumulate stage
interface product_accumulator_if #(parameter int PW = 64, parameter int AW = 72, parameter int LW = 8);
  logic start;
  logic [LW-1:0] len;
  logic abort;
  logic prod_valid;
  logic [PW-1:0] prod;
  logic prod_ready;
  logic acc_valid;
  logic [AW-1:0] acc;
  logic ovf;
  logic acc_ready;
  logic busy;
  modport master (
    output start, len, abort, prod_valid, prod, acc_ready,
    input prod_ready, acc_valid, acc, ovf, busy
  );
  modport slave (
    input start, len, abort, prod_valid, prod, acc_ready,
    output prod_ready, acc_valid, acc, ovf, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed count of unsigned products into a wide accumulator with sticky overflow
module product_accumulator #(parameter int PW = 64, parameter int AW = 72, parameter int LW = 8) (
  input logic clk,
  input logic rst_n,
  product_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nxt;
  logic [LW-1:0] cnt;
  logic [AW-1:0] acc_q;
  logic ovf_q;
  logic [AW:0] sum;
  logic launch, xfer;
  assign launch = state == IDLE && bus.start && !bus.abort;
  assign bus.prod_ready = state == ACC && !bus.abort;
  assign xfer = bus.prod_valid && bus.prod_ready;
  assign sum = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, bus.prod};
  assign bus.acc_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.acc = acc_q;
  assign bus.ovf = ovf_q;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = launch ? (bus.len == '0 ? DONE : ACC) : IDLE;
      ACC: state_nxt = bus.abort ? IDLE : (xfer && cnt == LW'(1)) ? DONE : ACC;
      DONE: state_nxt = (bus.abort || bus.acc_ready) ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
        cnt <= bus.len;
      end else if (xfer) begin
        acc_q <= sum[AW-1:0];
        ovf_q <= ovf_q | sum[AW];
        cnt <= cnt - LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed and randomized checks with a queued golden-sum scoreboard
module tb_product_accumulator;
  logic clk, rst_n;
  int total, bad;
  logic [63:0] prods[$];
  logic [72:0] sb[$];
  product_accumulator_if #(.PW(64), .AW(72), .LW(8)) ifa ();
  product_accumulator_if #(.PW(64), .AW(64), .LW(8)) ifb ();
  product_accumulator #(.PW(64), .AW(72), .LW(8)) ua (.clk(clk), .rst_n(rst_n), .bus(ifa));
  product_accumulator #(.PW(64), .AW(64), .LW(8)) ub (.clk(clk), .rst_n(rst_n), .bus(ifb));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic run_a(input int gap, input int hold);
    logic [79:0] gs;
    logic [72:0] exp;
    int n;
    n = prods.size();
    gs = '0;
    foreach (prods[i]) gs += 80'(prods[i]);
    sb.push_back({gs[79:72] != 0, gs[71:0]});
    ifa.start = 1'b1;
    ifa.len = 8'(n);
    tick;
    ifa.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("busy_run", ifa.busy, 1'b1);
      repeat (gap) begin
        ifa.prod_valid = 1'b0;
        tick;
      end
      ifa.prod_valid = 1'b1;
      ifa.prod = prods[i];
      check("prod_ready", ifa.prod_ready, 1'b1);
      check("early_valid", ifa.acc_valid, 1'b0);
      tick;
      ifa.prod_valid = 1'b0;
    end
    check("latency", ifa.acc_valid, 1'b1);
    check("done_noready", ifa.prod_ready, 1'b0);
    exp = sb.size() > 0 ? sb[0] : '0;
    repeat (hold) begin
      ifa.acc_ready = 1'b0;
      tick;
      check("hold_valid", ifa.acc_valid, 1'b1);
      check("hold_acc", ifa.acc, exp[71:0]);
    end
    if (sb.size() == 0) check("sb_empty", 1'b1, 1'b0);
    else begin
      exp = sb.pop_front();
      check("acc", ifa.acc, exp[71:0]);
      check("ovf", ifa.ovf, exp[72]);
    end
    ifa.acc_ready = 1'b1;
    tick;
    ifa.acc_ready = 1'b0;
    check("idle_after", ifa.busy, 1'b0);
    check("valid_after", ifa.acc_valid, 1'b0);
  endtask
  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    {ifa.start, ifa.len, ifa.abort, ifa.prod_valid, ifa.prod, ifa.acc_ready} = '0;
    {ifb.start, ifb.len, ifb.abort, ifb.prod_valid, ifb.prod, ifb.acc_ready} = '0;
    tick;
    tick;
    check("rst_busy", ifa.busy, 1'b0);
    check("rst_acc", ifa.acc, 72'h0);
    check("rst_ready", ifa.prod_ready, 1'b0);
    rst_n = 1'b1;
    tick;
    // T1: reset mid-run clears everything without completing
    ifa.start = 1'b1;
    ifa.len = 8'd3;
    tick;
    ifa.start = 1'b0;
    ifa.prod_valid = 1'b1;
    ifa.prod = 64'd5;
    tick;
    ifa.prod_valid = 1'b0;
    check("t1_partial", ifa.acc, 72'd5);
    rst_n = 1'b0;
    #1;
    check("t1_busy", ifa.busy, 1'b0);
    check("t1_ready", ifa.prod_ready, 1'b0);
    check("t1_valid", ifa.acc_valid, 1'b0);
    check("t1_acc", ifa.acc, 72'h0);
    check("t1_ovf", ifa.ovf, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    check("t1_idle", ifa.busy, 1'b0);
    check("t1_idle_ready", ifa.prod_ready, 1'b0);
    // T2: back-to-back products
    prods = '{64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF};
    run_a(0, 0);
    check("t2_acc", ifa.acc, 72'h1_0000_0000_0000_000B);
    check("t2_ovf", ifa.ovf, 1'b0);
    // T3: gaps and backpressure
    prods = '{64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210};
    run_a(4, 5);
    check("t3_acc", ifa.acc, 72'h1_1111_1111_1111_1100);
    // T4: empty run
    ifa.start = 1'b1;
    ifa.len = 8'd0;
    ifa.prod_valid = 1'b1;
    ifa.prod = 64'd99;
    tick;
    ifa.start = 1'b0;
    check("t4_valid", ifa.acc_valid, 1'b1);
    check("t4_acc", ifa.acc, 72'h0);
    check("t4_noready", ifa.prod_ready, 1'b0);
    ifa.acc_ready = 1'b1;
    tick;
    ifa.acc_ready = 1'b0;
    ifa.prod_valid = 1'b0;
    check("t4_idle", ifa.busy, 1'b0);
    check("t4_acc_kept", ifa.acc, 72'h0);
    // T5: wrap at 64 bits sets sticky ovf, cleared by next run
    ifb.start = 1'b1;
    ifb.len = 8'd2;
    tick;
    ifb.start = 1'b0;
    ifb.prod_valid = 1'b1;
    ifb.prod = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    ifb.prod = 64'd2;
    tick;
    ifb.prod_valid = 1'b0;
    check("t5_valid", ifb.acc_valid, 1'b1);
    check("t5_acc", ifb.acc, 64'd1);
    check("t5_ovf", ifb.ovf, 1'b1);
    ifb.acc_ready = 1'b1;
    tick;
    ifb.acc_ready = 1'b0;
    check("t5_ovf_kept", ifb.ovf, 1'b1);
    ifb.start = 1'b1;
    ifb.len = 8'd1;
    tick;
    ifb.start = 1'b0;
    ifb.prod_valid = 1'b1;
    ifb.prod = 64'd4;
    tick;
    ifb.prod_valid = 1'b0;
    check("t5b_valid", ifb.acc_valid, 1'b1);
    check("t5b_acc", ifb.acc, 64'd4);
    check("t5b_ovf", ifb.ovf, 1'b0);
    ifb.acc_ready = 1'b1;
    tick;
    ifb.acc_ready = 1'b0;
    // T6: start while busy ignored, abort wins over a pending transfer
    ifa.start = 1'b1;
    ifa.len = 8'd4;
    tick;
    ifa.start = 1'b0;
    ifa.prod_valid = 1'b1;
    ifa.prod = 64'd10;
    tick;
    tick;
    ifa.prod_valid = 1'b0;
    ifa.start = 1'b1;
    ifa.len = 8'd9;
    tick;
    ifa.start = 1'b0;
    check("t6_busy", ifa.busy, 1'b1);
    check("t6_acc2", ifa.acc, 72'd20);
    ifa.prod_valid = 1'b1;
    ifa.prod = 64'd1;
    tick;
    ifa.prod_valid = 1'b0;
    check("t6_still_acc", ifa.busy, 1'b1);
    check("t6_novalid", ifa.acc_valid, 1'b0);
    ifa.abort = 1'b1;
    ifa.prod_valid = 1'b1;
    ifa.prod = 64'd1000;
    #1;
    check("t6_abort_ready", ifa.prod_ready, 1'b0);
    tick;
    ifa.abort = 1'b0;
    ifa.prod_valid = 1'b0;
    check("t6_idle", ifa.busy, 1'b0);
    check("t6_valid", ifa.acc_valid, 1'b0);
    check("t6_no_xfer", ifa.acc, 72'd21);
    ifa.abort = 1'b1;
    ifa.start = 1'b1;
    ifa.len = 8'd3;
    tick;
    ifa.abort = 1'b0;
    ifa.start = 1'b0;
    check("t6_start_abort", ifa.busy, 1'b0);
    ifa.start = 1'b1;
    ifa.len = 8'd0;
    tick;
    ifa.start = 1'b0;
    ifa.abort = 1'b1;
    ifa.acc_ready = 1'b1;
    tick;
    ifa.abort = 1'b0;
    ifa.acc_ready = 1'b0;
    check("t6_abort_done", ifa.acc_valid, 1'b0);
    check("t6_abort_done_idle", ifa.busy, 1'b0);
    // randomized runs of multiplier products against the golden sum
    for (int r = 0; r < 300; r++) begin
      prods = {};
      for (int k = 0; k < int'($urandom_range(1, 12)); k++)
        prods.push_back(64'($urandom) * 64'($urandom));
      run_a(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
